// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load-data alignment, wait-for-RAM FSM and load timeout.
// Misaligned loads raise adel_o; loads that never see ram_rvalid_i raise berr_o.
module mem_wb_stage #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        mem_valid_i,
  input  logic        mem_wreg_i,
  input  logic [4:0]  mem_wd_i,
  input  logic [31:0] mem_wdata_i,
  input  logic        mem_is_load_i,
  input  logic [2:0]  mem_load_op_i,
  input  logic [1:0]  mem_addr_lo_i,
  input  logic [31:0] ram_rdata_i,
  input  logic        ram_rvalid_i,
  output logic        wb_we_o,
  output logic [4:0]  wb_waddr_o,
  output logic [31:0] wb_wdata_o,
  output logic        stallreq_o,
  output logic        adel_o,
  output logic        berr_o
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

  typedef enum logic {StIdle, StWait} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wreg_q, wreg_d;
  logic [4:0]      wd_q, wd_d;
  logic [2:0]      op_q, op_d;
  logic [1:0]      off_q, off_d;
  logic            we_q, we_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            adel_q, adel_d;
  logic            berr_q, berr_d;

  function automatic logic [31:0] align_load(input logic [2:0] op, input logic [1:0] off,
                                             input logic [31:0] rdata);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = rdata >> {off, 3'b000};
    b  = sh[7:0];
    h  = off[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      3'b001:  return {{24{b[7]}}, b};
      3'b010:  return {24'h0, b};
      3'b011:  return {{16{h[15]}}, h};
      3'b100:  return {16'h0, h};
      default: return rdata;
    endcase
  endfunction

  // Unknown load codes behave as LW, so they need word alignment too.
  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] off);
    case (op)
      3'b001, 3'b010: return 1'b0;
      3'b011, 3'b100: return off[0];
      default:        return off != 2'b00;
    endcase
  endfunction

  logic new_misaligned;
  assign new_misaligned = misaligned(mem_load_op_i, mem_addr_lo_i);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wreg_d  = wreg_q;
    wd_d    = wd_q;
    op_d    = op_q;
    off_d   = off_q;
    we_d    = 1'b0;
    waddr_d = 5'd0;
    wdata_d = 32'd0;
    adel_d  = 1'b0;
    berr_d  = 1'b0;
    if (flush_i) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mem_valid_i) begin
            if (!mem_is_load_i) begin
              we_d    = mem_wreg_i;
              waddr_d = mem_wd_i;
              wdata_d = mem_wdata_i;
            end else if (new_misaligned) begin
              adel_d = 1'b1;
            end else if (ram_rvalid_i) begin
              we_d    = mem_wreg_i;
              waddr_d = mem_wd_i;
              wdata_d = align_load(mem_load_op_i, mem_addr_lo_i, ram_rdata_i);
            end else begin
              state_d = StWait;
              cnt_d   = '0;
              wreg_d  = mem_wreg_i;
              wd_d    = mem_wd_i;
              op_d    = mem_load_op_i;
              off_d   = mem_addr_lo_i;
            end
          end
        end
        StWait: begin
          if (cnt_q == TimeoutCnt) begin
            berr_d  = 1'b1;
            state_d = StIdle;
            cnt_d   = '0;
          end else if (ram_rvalid_i) begin
            we_d    = wreg_q;
            waddr_d = wd_q;
            wdata_d = align_load(op_q, off_q, ram_rdata_i);
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    stallreq_o = 1'b0;
    if (!rst) begin
      if (state_q == StIdle) begin
        stallreq_o = mem_valid_i && mem_is_load_i && !ram_rvalid_i && !new_misaligned;
      end else begin
        stallreq_o = !ram_rvalid_i && (cnt_q < TimeoutCnt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wreg_q  <= 1'b0;
      wd_q    <= 5'd0;
      op_q    <= 3'd0;
      off_q   <= 2'd0;
      we_q    <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= 32'd0;
      adel_q  <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wreg_q  <= wreg_d;
      wd_q    <= wd_d;
      op_q    <= op_d;
      off_q   <= off_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      adel_q  <= adel_d;
      berr_q  <= berr_d;
    end
  end

  assign wb_we_o    = we_q;
  assign wb_waddr_o = waddr_q;
  assign wb_wdata_o = wdata_q;
  assign adel_o     = adel_q;
  assign berr_o     = berr_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: vector table for single-cycle cases plus
// hand sequences for wait, timeout, flush and reset-in-wait.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic        mem_valid_i;
  logic        mem_wreg_i;
  logic [4:0]  mem_wd_i;
  logic [31:0] mem_wdata_i;
  logic        mem_is_load_i;
  logic [2:0]  mem_load_op_i;
  logic [1:0]  mem_addr_lo_i;
  logic [31:0] ram_rdata_i;
  logic        ram_rvalid_i;
  logic        wb_we_o;
  logic [4:0]  wb_waddr_o;
  logic [31:0] wb_wdata_o;
  logic        stallreq_o;
  logic        adel_o;
  logic        berr_o;

  mem_wb_stage #(.TIMEOUT(15)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush_i),
    .mem_valid_i   (mem_valid_i),
    .mem_wreg_i    (mem_wreg_i),
    .mem_wd_i      (mem_wd_i),
    .mem_wdata_i   (mem_wdata_i),
    .mem_is_load_i (mem_is_load_i),
    .mem_load_op_i (mem_load_op_i),
    .mem_addr_lo_i (mem_addr_lo_i),
    .ram_rdata_i   (ram_rdata_i),
    .ram_rvalid_i  (ram_rvalid_i),
    .wb_we_o       (wb_we_o),
    .wb_waddr_o    (wb_waddr_o),
    .wb_wdata_o    (wb_wdata_o),
    .stallreq_o    (stallreq_o),
    .adel_o        (adel_o),
    .berr_o        (berr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        adel;
    logic        berr;
  } out_t;

  typedef struct {
    string       nm;
    logic        valid;
    logic        wreg;
    logic [4:0]  wd;
    logic [31:0] wdata;
    logic        is_load;
    logic [2:0]  op;
    logic [1:0]  off;
    logic [31:0] rdata;
    logic        rvalid;
    logic        ewe;
    logic [4:0]  ewaddr;
    logic [31:0] ewdata;
    logic        eadel;
    logic        estall;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  out_t exp_q[$];
  vec_t vecs[18];

  localparam out_t Zero = '{we: 1'b0, waddr: 5'd0, wdata: 32'd0, adel: 1'b0, berr: 1'b0};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic valid, input logic wreg, input logic [4:0] wd,
                        input logic [31:0] wdata, input logic is_load, input logic [2:0] op,
                        input logic [1:0] off, input logic [31:0] rdata, input logic rvalid);
    mem_valid_i   = valid;
    mem_wreg_i    = wreg;
    mem_wd_i      = wd;
    mem_wdata_i   = wdata;
    mem_is_load_i = is_load;
    mem_load_op_i = op;
    mem_addr_lo_i = off;
    ram_rdata_i   = rdata;
    ram_rvalid_i  = rvalid;
  endtask

  // Called at posedge+1 with inputs applied; returns at the next posedge+1.
  task automatic cycle(input string nm, input out_t e, input logic exp_stall);
    out_t got;
    out_t want;
    #1;
    chk({nm, ".stall"}, {63'd0, stallreq_o}, {63'd0, exp_stall});
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got  = '{we: wb_we_o, waddr: wb_waddr_o, wdata: wb_wdata_o, adel: adel_o, berr: berr_o};
    want = exp_q.pop_front();
    chk({nm, ".out"}, {24'd0, got}, {24'd0, want});
  endtask

  initial begin
    int   n;
    out_t e;

    vecs[0]  = '{"add",     1, 1,  5, 32'h1234, 0, 3'd0, 2'd0, 32'h0,        0,
                 1,  5, 32'h00001234, 0, 0};
    vecs[1]  = '{"lb_off3", 1, 1,  7, 32'h0,    1, 3'd1, 2'd3, 32'h80FF0011, 1,
                 1,  7, 32'hFFFFFF80, 0, 0};
    vecs[2]  = '{"lbu_off3",1, 1,  7, 32'h0,    1, 3'd2, 2'd3, 32'h80FF0011, 1,
                 1,  7, 32'h00000080, 0, 0};
    vecs[3]  = '{"lb_off2", 1, 1,  8, 32'h0,    1, 3'd1, 2'd2, 32'h80FF0011, 1,
                 1,  8, 32'hFFFFFFFF, 0, 0};
    vecs[4]  = '{"lb_off0", 1, 1,  8, 32'h0,    1, 3'd1, 2'd0, 32'h80FF0011, 1,
                 1,  8, 32'h00000011, 0, 0};
    vecs[5]  = '{"lh_off0", 1, 1,  9, 32'h0,    1, 3'd3, 2'd0, 32'h12348001, 1,
                 1,  9, 32'hFFFF8001, 0, 0};
    vecs[6]  = '{"lhu_off2",1, 1,  9, 32'h0,    1, 3'd4, 2'd2, 32'h80FF0011, 1,
                 1,  9, 32'h000080FF, 0, 0};
    vecs[7]  = '{"lh_off2", 1, 1, 11, 32'h0,    1, 3'd3, 2'd2, 32'h7FFF0000, 1,
                 1, 11, 32'h00007FFF, 0, 0};
    vecs[8]  = '{"lw",      1, 1, 31, 32'h0,    1, 3'd0, 2'd0, 32'hDEADBEEF, 1,
                 1, 31, 32'hDEADBEEF, 0, 0};
    vecs[9]  = '{"op7_lw",  1, 1, 30, 32'h0,    1, 3'd7, 2'd0, 32'hCAFEF00D, 1,
                 1, 30, 32'hCAFEF00D, 0, 0};
    vecs[10] = '{"invalid", 0, 1,  9, 32'hFFFF, 0, 3'd0, 2'd0, 32'h0,        0,
                 0,  0, 32'h0,        0, 0};
    vecs[11] = '{"r0_write",1, 1,  0, 32'h55,   0, 3'd0, 2'd0, 32'h0,        0,
                 1,  0, 32'h00000055, 0, 0};
    vecs[12] = '{"ld_nowreg",1,0,  3, 32'h0,    1, 3'd0, 2'd0, 32'h11223344, 1,
                 0,  3, 32'h11223344, 0, 0};
    vecs[13] = '{"mis_lw1", 1, 1,  4, 32'h0,    1, 3'd0, 2'd1, 32'h0,        0,
                 0,  0, 32'h0,        1, 0};
    vecs[14] = '{"mis_lh3", 1, 1,  4, 32'h0,    1, 3'd3, 2'd3, 32'h12345678, 1,
                 0,  0, 32'h0,        1, 0};
    vecs[15] = '{"mis_lhu1",1, 1,  4, 32'h0,    1, 3'd4, 2'd1, 32'h0,        0,
                 0,  0, 32'h0,        1, 0};
    vecs[16] = '{"mis_op5", 1, 1,  4, 32'h0,    1, 3'd5, 2'd2, 32'h0,        0,
                 0,  0, 32'h0,        1, 0};
    vecs[17] = '{"add_nowr",1, 0,  2, 32'hA,    0, 3'd0, 2'd0, 32'h0,        0,
                 0,  2, 32'h0000000A, 0, 0};

    // Reset with a pending load on the inputs: stall must stay low.
    rst     = 1'b1;
    flush_i = 1'b0;
    set_in(1, 1, 5, 32'h1, 1, 3'd0, 2'd0, 32'h0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset.out", {24'd0, wb_we_o, wb_waddr_o, wb_wdata_o, adel_o, berr_o}, 64'd0);
    chk("reset.stall", {63'd0, stallreq_o}, 64'd0);
    rst = 1'b0;
    set_in(0, 0, 0, 32'h0, 0, 3'd0, 2'd0, 32'h0, 0);

    foreach (vecs[i]) begin
      set_in(vecs[i].valid, vecs[i].wreg, vecs[i].wd, vecs[i].wdata, vecs[i].is_load,
             vecs[i].op, vecs[i].off, vecs[i].rdata, vecs[i].rvalid);
      e = '{we: vecs[i].ewe, waddr: vecs[i].ewaddr, wdata: vecs[i].ewdata,
            adel: vecs[i].eadel, berr: 1'b0};
      cycle(vecs[i].nm, e, vecs[i].estall);
    end

    // LH waiting three cycles; inputs scrambled in WAIT to prove captured copies are used.
    set_in(1, 1, 10, 32'h0, 1, 3'd3, 2'd2, 32'h0, 0);
    cycle("lhwait.idle", Zero, 1'b1);
    set_in(1, 0, 1, 32'h0, 1, 3'd0, 2'd0, 32'h0, 0);
    cycle("lhwait.w1", Zero, 1'b1);
    cycle("lhwait.w2", Zero, 1'b1);
    ram_rdata_i  = 32'hBEEF0000;
    ram_rvalid_i = 1'b1;
    cycle("lhwait.done", '{we: 1'b1, waddr: 5'd10, wdata: 32'hFFFFBEEF, adel: 1'b0, berr: 1'b0},
          1'b0);

    // Timeout: count stall cycles, then rvalid arriving at the timeout cycle loses.
    set_in(1, 1, 12, 32'h0, 1, 3'd0, 2'd0, 32'h0, 0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!stallreq_o) break;
      n++;
      @(posedge clk);
      #1;
      chk("timeout.quiet", {62'd0, wb_we_o, berr_o}, 64'd0);
    end
    chk("timeout.stall_cycles", 64'(n), 64'd16);
    ram_rdata_i  = 32'h11111111;
    ram_rvalid_i = 1'b1;
    cycle("timeout.berr", '{we: 1'b0, waddr: 5'd0, wdata: 32'd0, adel: 1'b0, berr: 1'b1}, 1'b0);
    set_in(0, 0, 0, 32'h0, 0, 3'd0, 2'd0, 32'h0, 0);
    cycle("timeout.after", Zero, 1'b0);

    // Flush in WAIT beats a same-cycle rvalid; next instruction goes through normally.
    set_in(1, 1, 4, 32'h0, 1, 3'd0, 2'd0, 32'h0, 0);
    cycle("flush.enter", Zero, 1'b1);
    flush_i      = 1'b1;
    ram_rdata_i  = 32'h99;
    ram_rvalid_i = 1'b1;
    cycle("flush.kill", Zero, 1'b0);
    flush_i = 1'b0;
    set_in(1, 1, 6, 32'h77, 0, 3'd0, 2'd0, 32'h0, 0);
    cycle("flush.next", '{we: 1'b1, waddr: 5'd6, wdata: 32'h77, adel: 1'b0, berr: 1'b0}, 1'b0);

    // Reset in WAIT abandons the load silently.
    set_in(1, 1, 14, 32'h0, 1, 3'd0, 2'd0, 32'h0, 0);
    cycle("rstwait.enter", Zero, 1'b1);
    rst          = 1'b1;
    ram_rvalid_i = 1'b1;
    ram_rdata_i  = 32'h5A5A5A5A;
    cycle("rstwait.rst", Zero, 1'b0);
    rst = 1'b0;
    set_in(0, 0, 0, 32'h0, 0, 3'd0, 2'd0, 32'h0, 0);
    cycle("rstwait.idle", Zero, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
